// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter and its helpers.
package uart_pkg;

    // Default byte width; the transmitter and arbiter must agree on it.
    localparam int DATA_WIDTH_DEFAULT = 8;

    // Arbiter FSM states. Encoding is exposed on the top's dbg_state port.
    typedef enum logic [1:0] {
        ARB       = 2'd0,  // idle, waiting for a request and an idle transmitter
        ISSUE     = 2'd1,  // tx_valid strobe cycle
        WAIT_BUSY = 2'd2,  // waiting for the transmitter to leave idle
        WAIT_DONE = 2'd3   // waiting for the transmitter to finish the frame
    } arb_state_t;

    // Even/odd parity bit for a byte as the transmitter would append it.
    function automatic logic parity_bit(input logic [DATA_WIDTH_DEFAULT-1:0] data,
                                        input logic                          odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req upward from ptr with
// wrap-around and returns the first set bit as a one-hot grant and an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    // First requester at or after ptr wins; later candidates are ignored.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(ptr) + k) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters.
//
// Handshakes:
//   Requester side: a requester holds req_valid with stable data until it
//   sees req_ready[i] high for one cycle; the byte is taken on that clock
//   edge. Dropping req_valid before req_ready withdraws the request.
//   Transmitter side: tx_valid is a one-cycle strobe issued only when the
//   transmitter was seen ready; tx_ready then falls, and its return to 1
//   marks frame completion. tx_data and parity config stay stable from
//   acceptance until the next acceptance.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int Data_Width     = DATA_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*Data_Width-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_parity_en,
    input  logic [NUM_REQ-1:0]           req_parity_type,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [Data_Width-1:0]        tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         parity_en,
    output logic                         parity_type,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         err_timeout,
    input  logic                         err_clear,
    output logic [1:0]                   dbg_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

    arb_state_t          state;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       wd_cnt;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic [IW-1:0]       next_ptr;
    logic                arb_open;
    logic                accept;
    logic                wd_expired;

    logic [Data_Width-1:0] sel_data;
    logic                  sel_pen;
    logic                  sel_ptype;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (pick_onehot),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // Arbitration is open when idle, or the moment the current frame completes
    // so back-to-back frames lose no cycle. Held closed during reset.
    assign arb_open   = reset && tx_ready && ((state == ARB) || (state == WAIT_DONE));
    assign accept     = arb_open && pick_valid;
    assign req_ready  = accept ? pick_onehot : '0;
    assign next_ptr   = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
    assign wd_expired = (wd_cnt == WD_LAST);
    assign dbg_state  = state;

    // Mux the winning requester's byte and parity configuration.
    always_comb begin
        sel_data  = '0;
        sel_pen   = 1'b0;
        sel_ptype = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_data  = req_data[i*Data_Width +: Data_Width];
                sel_pen   = req_parity_en[i];
                sel_ptype = req_parity_type[i];
            end
        end
    end

    // Arbiter FSM with registered transmitter-facing outputs and watchdog.
    // wd_cnt reads 0 in the issue cycle and counts cycles since issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            parity_en   <= 1'b0;
            parity_type <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (err_clear) begin
                err_timeout <= 1'b0;
            end

            if (accept) begin
                tx_data     <= sel_data;
                parity_en   <= sel_pen;
                parity_type <= sel_ptype;
                grant_id    <= pick_idx;
                rr_ptr      <= next_ptr;
                busy        <= 1'b1;
                tx_valid    <= 1'b1;
                wd_cnt      <= '0;
                state       <= ISSUE;
            end else begin
                case (state)
                    ARB: begin
                        state <= ARB;
                    end
                    ISSUE: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        state  <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (wd_expired) begin
                            // A new timeout beats a coincident err_clear.
                            err_timeout <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ARB;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                            if (!tx_ready) begin
                                state <= WAIT_DONE;
                            end
                        end
                    end
                    WAIT_DONE: begin
                        if (tx_ready) begin
                            busy  <= 1'b0;
                            state <= ARB;
                        end else if (wd_expired) begin
                            err_timeout <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ARB;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ARB;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural transmitter that stays busy
// for FRAME cycles after each tx_valid.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;
    localparam int FRAME   = 20;
    localparam int EW      = 13;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_parity_en;
    logic [N-1:0]   req_parity_type;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           parity_en;
    logic           parity_type;
    logic [1:0]     grant_id;
    logic           busy;
    logic           err_timeout;
    logic           err_clear;
    logic [1:0]     dbg_state;

    int             n_tests;
    int             n_fail;
    logic [EW-1:0]  exp_q[$];
    int             reps_left[N];
    logic           force_low;
    int             tx_cnt;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .Data_Width     (W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_parity_en   (req_parity_en),
        .req_parity_type (req_parity_type),
        .req_ready       (req_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .grant_id        (grant_id),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_clear       (err_clear),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transmitter model ----------------
    assign tx_ready = !force_low && (tx_cnt == 0) && !tx_valid;

    always @(posedge clk or negedge reset) begin
        if (!reset) tx_cnt <= 0;
        else if (tx_valid && tx_cnt == 0) tx_cnt <= FRAME;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] item(input logic [1:0] id, input logic pen,
                                           input logic pt, input logic pb,
                                           input logic [W-1:0] data);
        return {id, pen, pt, pb, data};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        err_clear = 1'b0;
        force_low = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [W-1:0] data, input logic pen,
                        input logic pt, input int reps);
        req_data[i*W +: W]  = data;
        req_parity_en[i]    = pen;
        req_parity_type[i]  = pt;
        reps_left[i]        = reps;
        req_valid[i]        = 1'b1;
    endtask

    // One cycle of requester behaviour: drop (or re-offer) after acceptance.
    task automatic step(output logic [N-1:0] acc);
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (reps_left[i] > 1) reps_left[i]--;
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        logic [N-1:0] a;
        int n;
        n = 0;
        forever begin
            step(a);
            n++;
            if (req_valid == '0 && exp_q.size() == 0 && !busy && dbg_state == 2'd0) break;
            if (n > budget) begin
                check({name, "_timeout"}, 32'(n), 32'(budget));
                break;
            end
        end
    endtask

    task automatic step_until_state(input string name, input logic [1:0] st, input int budget);
        logic [N-1:0] a;
        int n;
        n = 0;
        while (dbg_state != st && n <= budget) begin
            step(a);
            n++;
        end
        if (n > budget) check({name, "_reach_state"}, 32'(dbg_state), 32'(st));
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] snap;
    logic          have_snap;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            have_snap <= 1'b0;
        end else begin
            if (req_ready != '0) begin
                check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
                if (have_snap)
                    check("held_until_next_accept",
                          32'({grant_id, parity_en, parity_type, tx_data}),
                          32'({snap[12:9], snap[7:0]}));
            end
            if (tx_valid) begin
                logic pb;
                pb = parity_en ? ((^tx_data) ^ parity_type) : 1'b0;
                snap      <= {grant_id, parity_en, parity_type, pb, tx_data};
                have_snap <= 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'({grant_id, tx_data}), 32'hFFFF_FFFF);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("frame", 32'({grant_id, parity_en, parity_type, pb, tx_data}), 32'(e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] a;
        int k;
        int hits;
        n_tests         = 0;
        n_fail          = 0;
        req_data        = '0;
        req_parity_en   = '0;
        req_parity_type = '0;
        for (int i = 0; i < N; i++) reps_left[i] = 0;

        // Reset values, with all requesters asserted during reset.
        reset     = 1'b0;
        err_clear = 1'b0;
        force_low = 1'b0;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_parity", 32'({parity_en, parity_type}), 32'd0);
        check("rst_grant_busy_err", 32'({grant_id, busy, err_timeout}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        do_reset();

        // Single requester 2, even parity.
        exp_q.push_back(item(2'd2, 1'b1, 1'b0, 1'b0, 8'hA5));
        post(2, 8'hA5, 1'b1, 1'b0, 1);
        k = 0;
        do begin
            step(a);
            k++;
        end while (a == '0 && k < 10);
        check("t1_req_ready", 32'(a), 32'h4);
        @(negedge clk);
        check("t1_tx_valid_next", 32'(tx_valid), 32'd1);
        check("t1_req_ready_one_cycle", 32'(req_ready), 32'd0);
        k = 1;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 2) check("t1_tx_valid_single", 32'(tx_valid), 32'd0);
        end
        check("t1_busy_fall", 32'(k), 32'(FRAME + 3));
        run_until_idle("t1", 50);

        // All four requesters; requester 0 stays for a second frame.
        do_reset();
        exp_q.push_back(item(2'd0, 1'b1, 1'b0, 1'b1, 8'h10));
        exp_q.push_back(item(2'd1, 1'b1, 1'b0, 1'b0, 8'h11));
        exp_q.push_back(item(2'd2, 1'b1, 1'b0, 1'b0, 8'h12));
        exp_q.push_back(item(2'd3, 1'b1, 1'b0, 1'b1, 8'h13));
        exp_q.push_back(item(2'd0, 1'b1, 1'b0, 1'b1, 8'h10));
        post(0, 8'h10, 1'b1, 1'b0, 2);
        post(1, 8'h11, 1'b1, 1'b0, 1);
        post(2, 8'h12, 1'b1, 1'b0, 1);
        post(3, 8'h13, 1'b1, 1'b0, 1);
        run_until_idle("t2", 400);

        // Mixed parity configuration per requester.
        do_reset();
        exp_q.push_back(item(2'd1, 1'b1, 1'b1, 1'b1, 8'h3C));
        exp_q.push_back(item(2'd3, 1'b0, 1'b0, 1'b0, 8'h7E));
        post(1, 8'h3C, 1'b1, 1'b1, 1);
        post(3, 8'h7E, 1'b0, 1'b0, 1);
        run_until_idle("t3", 200);

        // Watchdog: transmitter never returns to ready.
        do_reset();
        exp_q.push_back(item(2'd0, 1'b0, 1'b0, 1'b0, 8'h55));
        post(0, 8'h55, 1'b0, 1'b0, 1);
        k = 0;
        do begin
            step(a);
            k++;
        end while (a == '0 && k < 10);
        @(negedge clk);
        check("t4_issue", 32'(tx_valid), 32'd1);
        force_low = 1'b1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (c == TIMEOUT - 1) check("t4_err_before", 32'({err_timeout, busy}), 32'b01);
            if (c == TIMEOUT) check("t4_err_at", 32'({err_timeout, busy}), 32'b10);
        end
        check("t4_state_arb", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1 err_clear = 1'b1;
        @(negedge clk);
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        @(posedge clk);
        #1 err_clear = 1'b0;
        @(negedge clk);
        check("t4_err_cleared", 32'(err_timeout), 32'd0);
        force_low = 1'b0;

        // Reset while waiting for the frame to finish.
        do_reset();
        exp_q.push_back(item(2'd1, 1'b1, 1'b0, 1'b0, 8'h99));
        post(1, 8'h99, 1'b1, 1'b0, 1);
        step_until_state("t5", 2'd3, 20);
        #2 reset = 1'b0;
        #1;
        check("t5_async_data", 32'({tx_data, parity_en, parity_type}), 32'd0);
        check("t5_async_ctl", 32'({grant_id, busy, tx_valid, dbg_state}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(item(2'd0, 1'b0, 1'b0, 1'b0, 8'h01));
        exp_q.push_back(item(2'd1, 1'b0, 1'b0, 1'b0, 8'h02));
        post(0, 8'h01, 1'b0, 1'b0, 1);
        post(1, 8'h02, 1'b0, 1'b0, 1);
        run_until_idle("t5", 200);

        // Request withdrawn while the transmitter is busy.
        do_reset();
        exp_q.push_back(item(2'd0, 1'b0, 1'b0, 1'b0, 8'h80));
        post(0, 8'h80, 1'b0, 1'b0, 1);
        step_until_state("t6", 2'd3, 20);
        post(1, 8'hC3, 1'b0, 1'b0, 1);
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            step(a);
            if (a[1]) hits++;
        end
        req_valid[1] = 1'b0;
        run_until_idle("t6", 100);
        for (int c = 0; c < 10; c++) begin
            step(a);
            if (a[1]) hits++;
        end
        check("t6_no_grant_dropped", 32'(hits), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Captures the winning request's byte and per-requester parity configuration.
- Issues a one-cycle tx_valid to the transmitter, then holds data and parity config stable until the frame completes.
- A watchdog flags a transmitter that never returns to ready.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- Data_Width, 8, byte width; must match the transmitter.
- TIMEOUT_CYCLES, 4096, maximum cycles from issue to frame completion before the error flag is raised.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*Data_Width  packed bytes; requester i uses slice [i*Data_Width +: Data_Width]
- req_parity_en  in  NUM_REQ  per-requester parity enable
- req_parity_type  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- tx_data  out  Data_Width  byte to transmitter
- tx_valid  out  1  one-cycle issue strobe to transmitter
- tx_ready  in  1  transmitter ready; drops combinationally while tx_valid is high
- parity_en  out  1  to transmitter
- parity_type  out  1  to transmitter
- grant_id  out  $clog2(NUM_REQ)  requester owning the current frame
- busy  out  1  high from acceptance until frame completion
- err_timeout  out  1  sticky watchdog flag
- err_clear  in  1  clears err_timeout

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = 0. State = ARB.
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- ARB:
  - If tx_ready=1 and any req_valid: pick the first set bit scanning from the pointer upward with wrap-around.
  - Same cycle: pulse req_ready[i]. On that edge, capture the byte into tx_data, capture parity_en/parity_type, and set grant_id=i, busy=1, pointer=(i+1) mod NUM_REQ. Go to ISSUE.
  - If tx_ready=0: no grant.
- ISSUE: tx_valid=1 for exactly one cycle; watchdog counter cleared. Go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_ready=0 (transmitter left idle), then go to WAIT_DONE.
- WAIT_DONE: wait for tx_ready=1 (transmitter DONE/IDLE). Then busy=0 and go to ARB; arbitration may grant on that same cycle.
- Latency:
  - Request accepted in cycle T; tx_valid high in T+1.
  - Earliest next acceptance is in the cycle tx_ready returns high.
- Stability: tx_data, parity_en, parity_type and grant_id are held constant from acceptance until the next acceptance. Parity config is never changed mid-frame.
- Requester rules:
  - Data must be stable while req_valid is high.
  - Deasserting req_valid before req_ready is allowed; the request is simply dropped.
  - Only one req_ready bit is ever high.
- Watchdog:
  - Counter runs in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: set err_timeout, busy=0, go to ARB.
  - err_clear clears the flag. If err_clear coincides with a new timeout, set wins.
- Simultaneous events: all NUM_REQ valid means grants rotate 0,1,2,3,0. A single persistent requester is re-granted every frame.
- Reset mid-frame: immediate return to reset values. The transmitter shares the same reset.

Decomposition:
- Package uart_pkg: arbiter state enum, default Data_Width.
- Sub-module rr_arbiter: combinational round-robin pick from (req vector, pointer) returning one-hot grant and index. Reusable for the receive side.

Test Plan:
- Only req_valid[2] with byte 0xA5, parity_en=1, type=0 → req_ready[2] pulses one cycle; tx_valid next cycle; tx_data=0xA5, grant_id=2; Tx line shows even-parity bit 0; busy falls 177 cycles later (OverSampling=16).
- All four requesters valid, bytes 0x10,0x11,0x12,0x13 → frames issued in order 0,1,2,3; requester 0 kept valid → granted again fifth.
- Requester 1 odd parity, requester 3 parity disabled, both valid → parity_type=1 held through frame 1, then parity_en=0 for frame 3; outputs never change mid-frame.
- tx_ready forced 0 after issue, TIMEOUT_CYCLES=64 → err_timeout=1 exactly 64 cycles after issue; busy=0; err_clear pulse → 0.
- Reset asserted in WAIT_DONE → all outputs 0 asynchronously; after release, pointer=0 and requester 0 wins over 1.
- req_valid[1] asserted then dropped while transmitter busy → no req_ready[1]; no frame issued.
